// File: rtl/uart_tx.sv
// UART transmitter: 16x oversampled baud divider, start/data/stop FSM,
// registered serial output with busy flag and frame-done pulse.
module uart_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = 163
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_uart,
   input  logic [DBIT-1:0] w_data,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int DIV_W = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
   localparam int S_W   = $clog2(S_MAX);
   localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_reg, state_next;
   logic [DIV_W-1:0] div_reg, div_next;
   logic [S_W-1:0]   s_reg, s_next;
   logic [N_W-1:0]   n_reg, n_next;
   logic [DBIT-1:0]  b_reg, b_next;
   logic             tx_reg, tx_next;
   logic             busy_reg;
   logic             tick;
   logic             done;

   assign tick = (state_reg != IDLE) && (div_reg == DIV_W'(DVSR - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         div_reg   <= '0;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
         tx_reg    <= 1'b1;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         div_reg   <= div_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
         tx_reg    <= tx_next;
         busy_reg  <= (state_next != IDLE);
      end
   end

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      done       = 1'b0;
      div_next   = (state_reg == IDLE || tick) ? '0 : div_reg + 1'b1;
      unique case (state_reg)
         IDLE: begin
            if (wr_uart) begin
               state_next = START;
               b_next     = w_data;
               s_next     = '0;
               n_next     = '0;
               div_next   = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_reg == S_W'(15)) begin
                  state_next = DATA;
                  s_next     = '0;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_reg == S_W'(15)) begin
                  s_next = '0;
                  b_next = b_reg >> 1;
                  if (n_reg == N_W'(DBIT - 1))
                     state_next = STOP;
                  else
                     n_next = n_reg + 1'b1;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_reg == S_W'(SB_TICK - 1)) begin
                  state_next = IDLE;
                  done       = 1'b1;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // tx is computed from the upcoming state so the flop shows the new level
      // in the first cycle of each phase
      unique case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = b_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   assign tx           = tx_reg;
   assign tx_busy      = busy_reg;
   assign tx_done_tick = done & reset;

endmodule
